// File: rtl/mem_pkg.sv
// mem_pkg
//   Shared types and constants for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM states
//   size_t      : load/store access size encoding (2'b11 is reserved)
//   AGE_W/AGE_SAT : width and saturation value of the IF starvation counter
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2,
      ERR_D   = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      SZ_WORD = 2'd0,
      SZ_HALF = 2'd1,
      SZ_BYTE = 2'd2
   } size_t;

   localparam int unsigned     AGE_W   = 4;
   localparam logic [AGE_W-1:0] AGE_SAT = '1;

endpackage : mem_pkg

// File: rtl/mem_lane_steer.sv
// mem_lane_steer
//   Combinational byte-lane logic for a 32-bit little-endian memory port.
//   Ports:
//     size_i       access size (size_t encoding, 2'b11 reserved)
//     addr_i       low two bits of the byte address
//     wdata_i      right-justified store data
//     be_o         byte enables, bit i = byte lane i
//     wdata_o      store data replicated across all lanes of its size
//     misaligned_o access cannot be issued (bad alignment or reserved size)
module mem_lane_steer
   import mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        misaligned_o
);

   always_comb begin
      be_o         = 4'b0000;
      wdata_o      = wdata_i;
      misaligned_o = 1'b0;
      case (size_t'(size_i))
         SZ_WORD: begin
            be_o         = 4'b1111;
            misaligned_o = (addr_i != 2'b00);
         end
         SZ_HALF: begin
            be_o         = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_o      = {2{wdata_i[15:0]}};
            misaligned_o = addr_i[0];
         end
         SZ_BYTE: begin
            be_o    = 4'b0001 << addr_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         default: begin
            // Reserved size: never reaches memory, reported as an error.
            misaligned_o = 1'b1;
         end
      endcase
   end

endmodule : mem_lane_steer

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and
//   data load/store (D). D has priority; an age counter forces IF to win
//   once after MAX_WAIT consecutive grants it lost while requesting.
//   All mem_* outputs, acks and read-data outputs are registered.
//
//   Handshake: a requester raises x_req and holds it (with stable
//   address/data) until x_ack pulses for one cycle. In the ack cycle it
//   must drop x_req or present its next request; the arbiter samples
//   requests only at the clock edge that ends an IDLE cycle. Toward memory,
//   mem_req is held with stable mem_* until the edge where mem_ready=1.
//
//   Ports:
//     clk, reset            rising-edge clock, synchronous active-low reset
//     if_req/if_addr        fetch request and word address
//     if_rdata/if_ack       fetch data and completion pulse
//     d_req/d_we/d_size/d_addr/d_wdata  data request
//     d_rdata/d_ack/d_err   raw load word, completion pulse, misalign error
//     stall                 some requester waits this cycle
//     mem_req/we/be/addr/wdata, mem_rdata/mem_ready  memory port
//     dbg_state             current FSM state, for observation only
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [1:0]    d_size,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          d_err,
   output logic          stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output arb_state_t    dbg_state
);

   localparam logic [AGE_W-1:0] MAX_WAIT_C = AGE_W'(MAX_WAIT);

   arb_state_t       state_q, state_d;
   logic [AGE_W-1:0] age_q, age_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [3:0]       mem_be_q, mem_be_d;
   logic [AW-1:0]    mem_addr_q, mem_addr_d;
   logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
   logic             if_ack_q, if_ack_d;
   logic             d_ack_q, d_ack_d;
   logic             d_err_q, d_err_d;
   logic [DW-1:0]    if_rdata_q, if_rdata_d;
   logic [DW-1:0]    d_rdata_q, d_rdata_d;

   logic [3:0]       d_be;
   logic [DW-1:0]    d_wdata_steered;
   logic             d_misaligned;

   // Fetch addresses are word aligned by contract; low bits are ignored.
   logic             unused_if_addr_lsb;
   assign unused_if_addr_lsb = ^if_addr[1:0];

   mem_lane_steer u_lane_steer (
      .size_i       (d_size),
      .addr_i       (d_addr[1:0]),
      .wdata_i      (d_wdata),
      .be_o         (d_be),
      .wdata_o      (d_wdata_steered),
      .misaligned_o (d_misaligned)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         age_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         d_err_q     <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         age_q       <= age_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         d_ack_q     <= d_ack_d;
         d_err_q     <= d_err_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      age_d       = age_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      d_ack_d     = 1'b0;
      d_err_d     = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;

      case (state_q)
         IDLE: begin
            if (d_req && d_misaligned) begin
               // Error is answered without touching memory.
               state_d = ERR_D;
               d_ack_d = 1'b1;
               d_err_d = 1'b1;
            end else if (d_req && (!if_req || (age_q < MAX_WAIT_C))) begin
               state_d     = BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_be_d    = d_be;
               mem_addr_d  = {d_addr[AW-1:2], 2'b00};
               mem_wdata_d = d_wdata_steered;
               // Age counts only grants that IF actually lost.
               if (if_req && (age_q != AGE_SAT)) begin
                  age_d = age_q + 1'b1;
               end
            end else if (if_req) begin
               state_d     = BUSY_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_be_d    = 4'b1111;
               mem_addr_d  = {if_addr[AW-1:2], 2'b00};
               mem_wdata_d = '0;
               age_d       = '0;
            end
         end
         BUSY_IF: begin
            if (mem_ready) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               if_rdata_d = mem_rdata;
               if_ack_d   = 1'b1;
            end
         end
         BUSY_D: begin
            if (mem_ready) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               d_rdata_d = mem_rdata;
               d_ack_d   = 1'b1;
            end
         end
         ERR_D: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign if_rdata  = if_rdata_q;
   assign if_ack    = if_ack_q;
   assign d_rdata   = d_rdata_q;
   assign d_ack     = d_ack_q;
   assign d_err     = d_err_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign dbg_state = state_q;

   assign stall = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   import mem_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   logic        if_req, if_ack, d_req, d_we, d_ack, d_err, stall;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  d_size;
   logic [3:0]  mem_be;
   arb_state_t  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .dbg_state(dbg_state)
   );

   // ---------------- driver tasks ----------------
   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      step(); step();
      reset = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      if_req = 1'b1; if_addr = 32'h0000_0100;
      reset = 1'b0;
      step(); step();
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %0h exp 0", mem_req); end
      n_checks++; if (if_ack !== 1'b0 || d_ack !== 1'b0 || d_err !== 1'b0) begin n_fail++; $display("FAIL rst_acks: got %0b%0b%0b exp 000", if_ack, d_ack, d_err); end
      n_checks++; if (mem_be !== 4'b0 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_bus: be %0h addr %0h we %0h exp 0", mem_be, mem_addr, mem_we); end
      n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d exp %0d", dbg_state, IDLE); end
      reset = 1'b1;
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_release_early: got %0h exp 0", mem_req); end
      step();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL rst_first_req: req %0h addr %0h exp 1 00000100", mem_req, mem_addr); end
      mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
      step();
      n_checks++; if (if_ack !== 1'b1) begin n_fail++; $display("FAIL rst_first_ack: got %0h exp 1", if_ack); end
      idle_inputs();
      step();
   endtask

   task automatic test_if_alone();
      idle_inputs();
      mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      if_req = 1'b1; if_addr = 32'h0040_0000;
      step();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL if_issue: req %0h addr %0h exp 1 00400000", mem_req, mem_addr); end
      n_checks++; if (mem_be !== 4'b1111 || mem_we !== 1'b0) begin n_fail++; $display("FAIL if_be_we: be %0b we %0h exp 1111 0", mem_be, mem_we); end
      n_checks++; if (if_ack !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL if_busy: ack %0h stall %0h exp 0 1", if_ack, stall); end
      step();
      n_checks++; if (if_ack !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL if_ack_data: ack %0h rdata %0h exp 1 deadbeef", if_ack, if_rdata); end
      n_checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL if_ack_cycle: stall %0h req %0h exp 0 0", stall, mem_req); end
      if_req = 1'b0; mem_rdata = 32'h5555_5555;
      step();
      n_checks++; if (if_ack !== 1'b0 || if_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL if_hold: ack %0h rdata %0h exp 0 deadbeef", if_ack, if_rdata); end
   endtask

   // Store byte, store half, load half issued back to back (ack cycle re-requests).
   task automatic test_back_to_back();
      idle_inputs();
      mem_ready = 1'b1; mem_rdata = 32'hA5A5_0F0F;
      d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h0000_1003; d_wdata = 32'h0000_00AB;
      step();
      n_checks++; if (mem_be !== 4'b1000 || mem_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_lanes: be %0b wdata %0h exp 1000 abababab", mem_be, mem_wdata); end
      n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_req !== 1'b1) begin n_fail++; $display("FAIL sb_cmd: we %0h addr %0h req %0h exp 1 1000 1", mem_we, mem_addr, mem_req); end
      step();
      n_checks++; if (d_ack !== 1'b1 || d_err !== 1'b0) begin n_fail++; $display("FAIL sb_ack: ack %0h err %0h exp 1 0", d_ack, d_err); end
      d_size = 2'b01; d_addr = 32'h0000_1002; d_wdata = 32'h0000_1234;
      step();
      n_checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'h1234_1234 || mem_req !== 1'b1) begin n_fail++; $display("FAIL sh_lanes: be %0b wdata %0h req %0h exp 1100 12341234 1", mem_be, mem_wdata, mem_req); end
      step();
      n_checks++; if (d_ack !== 1'b1) begin n_fail++; $display("FAIL sh_ack: got %0h exp 1", d_ack); end
      d_we = 1'b0; d_size = 2'b01; d_addr = 32'h0000_2000;
      step();
      n_checks++; if (mem_be !== 4'b0011 || mem_we !== 1'b0 || mem_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL lh_cmd: be %0b we %0h addr %0h exp 0011 0 2000", mem_be, mem_we, mem_addr); end
      step();
      n_checks++; if (d_ack !== 1'b1 || d_rdata !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL lh_data: ack %0h rdata %0h exp 1 a5a50f0f", d_ack, d_rdata); end
      idle_inputs();
      step();
   endtask

   task automatic test_misaligned();
      logic [1:0]  sz_tab[3]   = '{2'b00, 2'b01, 2'b11};
      logic [31:0] addr_tab[3] = '{32'h0000_1001, 32'h0000_1003, 32'h0000_1000};
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         d_req = 1'b1; d_we = 1'b0; d_size = sz_tab[i]; d_addr = addr_tab[i];
         step();
         n_checks++; if (d_ack !== 1'b1 || d_err !== 1'b1) begin n_fail++; $display("FAIL mis_err[%0d]: ack %0h err %0h exp 1 1", i, d_ack, d_err); end
         n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_noreq[%0d]: got %0h exp 0", i, mem_req); end
         d_req = 1'b0;
         step();
         n_checks++; if (d_ack !== 1'b0 || d_err !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_after[%0d]: ack %0h err %0h req %0h exp 0 0 0", i, d_ack, d_err, mem_req); end
      end
   endtask

   task automatic test_age_fairness();
      logic exp_if;
      do_reset();
      mem_ready = 1'b1;
      if_req = 1'b1; if_addr = 32'h0000_2000;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h0000_3000;
      for (int i = 0; i < 10; i++) begin
         exp_if = (i == 4) || (i == 9);
         step();
         n_checks++; if (mem_req !== 1'b1 || mem_addr !== (exp_if ? 32'h0000_2000 : 32'h0000_3000)) begin n_fail++; $display("FAIL grant[%0d]: req %0h addr %0h exp_if %0b", i, mem_req, mem_addr, exp_if); end
         step();
         n_checks++; if (if_ack !== exp_if || d_ack !== !exp_if) begin n_fail++; $display("FAIL grant_ack[%0d]: if_ack %0h d_ack %0h exp_if %0b", i, if_ack, d_ack, exp_if); end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_wait_states();
      idle_inputs();
      d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h0000_4000; d_wdata = 32'h0BAD_F00D;
      step();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_4000 || mem_wdata !== 32'h0BAD_F00D || mem_be !== 4'b1111 || mem_we !== 1'b1) begin n_fail++; $display("FAIL wait_stable[%0d]: req %0h addr %0h wdata %0h be %0b we %0h", i, mem_req, mem_addr, mem_wdata, mem_be, mem_we); end
         n_checks++; if (stall !== 1'b1 || d_ack !== 1'b0) begin n_fail++; $display("FAIL wait_stall[%0d]: stall %0h ack %0h exp 1 0", i, stall, d_ack); end
         if (i < 2) step();
      end
      mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
      step();
      n_checks++; if (d_ack !== 1'b1 || d_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wait_done: ack %0h rdata %0h exp 1 cafef00d", d_ack, d_rdata); end
      idle_inputs();
      step();
      // Abandon an IF cycle with reset while memory is still waiting.
      if_req = 1'b1; if_addr = 32'h0000_5000;
      step();
      n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %0h exp 1", mem_req); end
      reset = 1'b0; if_req = 1'b0;
      step();
      n_checks++; if (mem_req !== 1'b0 || dbg_state !== IDLE || if_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset: req %0h state %0d rdata %0h exp 0 0 0", mem_req, dbg_state, if_rdata); end
      reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++; if (if_ack !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL no_stale_ack[%0d]: ack %0h req %0h exp 0 0", i, if_ack, mem_req); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle_inputs();
      reset = 1'b0;
      test_reset();
      test_if_alone();
      test_back_to_back();
      test_misaligned();
      test_age_fairness();
      test_wait_states();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mem_port_arbiter
